// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI flash command sequencer.
// State encoding, address length and the default stall limit live here.
package spi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_RDATA,
    S_END
  } state_t;

  localparam int ADDR_BYTES  = 3;
  localparam int TMO_CYC_DEF = 64;

  // Address goes out MSB byte first: index 0 is addr[23:16].
  function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [7:0] idx);
    case (idx)
      8'd0:    return addr[23:16];
      8'd1:    return addr[15:8];
      default: return addr[7:0];
    endcase
  endfunction

endpackage

// File: rtl/spi_seq_wdog.sv
// Engine-stall counter: counts clocks while enabled and raises O_expire once
// TMO_CYC clocks pass without a clear (done pulse or state change).
module spi_seq_wdog #(
  parameter int TMO_CYC = 64
) (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_en,
  input  logic I_clr,
  output logic O_expire
);

  localparam int CW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign O_expire = I_en && (cnt_q == CW'(TMO_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (I_clr || !I_en) begin
      cnt_d = '0;
    end else if (!O_expire) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_flash_seq.sv
// SPI flash transaction sequencer: cmd, optional 3-byte address, write payload, read payload.
// Define SPI_SEQ_TIMEOUT_EN to add the engine-stall abort (spi_seq_wdog).
module spi_flash_seq
  import spi_pkg::*;
#(
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_start,
  input  logic [7:0]  I_cmd,
  input  logic [23:0] I_addr,
  input  logic        I_addr_en,
  input  logic [7:0]  I_wr_len,
  input  logic [7:0]  I_rd_len,
  input  logic [7:0]  I_wr_data,
  output logic        O_wr_req,
  output logic [7:0]  O_rd_data,
  output logic        O_rd_valid,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_err,
  output logic        O_eng_tx_en,
  output logic        O_eng_rx_en,
  output logic [7:0]  O_eng_data,
  input  logic        I_eng_tx_done,
  input  logic        I_eng_rx_done,
  input  logic [7:0]  I_eng_data
);

  state_t      state_q, state_d;
  logic [23:0] addr_q, addr_d;
  logic        addr_en_q, addr_en_d;
  logic [7:0]  wr_len_q, wr_len_d;
  logic [7:0]  rd_len_q, rd_len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        tx_en_q, tx_en_d;
  logic        rx_en_q, rx_en_d;
  logic [7:0]  eng_data_q, eng_data_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        to_payload, to_read, finish;
  logic        tmo_expire;

`ifdef SPI_SEQ_TIMEOUT_EN
  logic wd_en, wd_clr;

  assign wd_en  = (state_q != S_IDLE) && (state_q != S_END);
  assign wd_clr = (state_d != state_q) | (tx_en_q & I_eng_tx_done) | (rx_en_q & I_eng_rx_done);

  spi_seq_wdog #(.TMO_CYC(TMO_CYC)) u_wdog (
    .I_clk    (I_clk),
    .I_rst_n  (I_rst_n),
    .I_en     (wd_en),
    .I_clr    (wd_clr),
    .O_expire (tmo_expire)
  );
`else
  logic [31:0] tmo_unused;
  assign tmo_unused = TMO_CYC;
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    addr_en_d  = addr_en_q;
    wr_len_d   = wr_len_q;
    rd_len_d   = rd_len_q;
    cnt_d      = cnt_q;
    tx_en_d    = tx_en_q;
    rx_en_d    = rx_en_q;
    eng_data_d = eng_data_q;
    rd_data_d  = rd_data_q;
    busy_d     = busy_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    O_wr_req   = 1'b0;
    to_payload = 1'b0;
    to_read    = 1'b0;
    finish     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (I_start) begin
          addr_d     = I_addr;
          addr_en_d  = I_addr_en;
          wr_len_d   = I_wr_len;
          rd_len_d   = I_rd_len;
          eng_data_d = I_cmd;
          tx_en_d    = 1'b1;
          busy_d     = 1'b1;
          cnt_d      = 8'd0;
          state_d    = S_CMD;
        end
      end
      S_CMD: begin
        if (I_eng_tx_done) begin
          if (addr_en_q) begin
            eng_data_d = addr_byte(addr_q, 8'd0);
            cnt_d      = 8'd0;
            state_d    = S_ADDR;
          end else begin
            to_payload = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (I_eng_tx_done) begin
          if (cnt_q != 8'(ADDR_BYTES - 1)) begin
            cnt_d      = cnt_q + 8'd1;
            eng_data_d = addr_byte(addr_q, cnt_q + 8'd1);
          end else begin
            to_payload = 1'b1;
          end
        end
      end
      S_WDATA: begin
        // cnt_q holds the number of payload bytes already handed to the engine.
        if (I_eng_tx_done) begin
          if (cnt_q != wr_len_q) begin
            eng_data_d = I_wr_data;
            O_wr_req   = 1'b1;
            cnt_d      = cnt_q + 8'd1;
          end else begin
            to_read = 1'b1;
          end
        end
      end
      S_RDATA: begin
        if (I_eng_rx_done) begin
          rd_data_d  = I_eng_data;
          rd_valid_d = 1'b1;
          cnt_d      = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == rd_len_q) finish = 1'b1;
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (to_payload) begin
      if (wr_len_q != 8'd0) begin
        eng_data_d = I_wr_data;
        O_wr_req   = 1'b1;
        cnt_d      = 8'd1;
        state_d    = S_WDATA;
      end else begin
        to_read = 1'b1;
      end
    end

    // Handing over tx->rx on the same edge keeps the engine's chip select asserted.
    if (to_read) begin
      if (rd_len_q != 8'd0) begin
        tx_en_d = 1'b0;
        rx_en_d = 1'b1;
        cnt_d   = 8'd0;
        state_d = S_RDATA;
      end else begin
        finish = 1'b1;
      end
    end

    if (finish) begin
      tx_en_d = 1'b0;
      rx_en_d = 1'b0;
      done_d  = 1'b1;
      busy_d  = 1'b0;
      cnt_d   = 8'd0;
      state_d = S_END;
    end

    if (tmo_expire) begin
      tx_en_d    = 1'b0;
      rx_en_d    = 1'b0;
      done_d     = 1'b1;
      err_d      = 1'b1;
      busy_d     = 1'b0;
      rd_valid_d = 1'b0;
      O_wr_req   = 1'b0;
      cnt_d      = 8'd0;
      state_d    = S_IDLE;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      addr_en_q  <= 1'b0;
      wr_len_q   <= '0;
      rd_len_q   <= '0;
      cnt_q      <= '0;
      tx_en_q    <= 1'b0;
      rx_en_q    <= 1'b0;
      eng_data_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      addr_en_q  <= addr_en_d;
      wr_len_q   <= wr_len_d;
      rd_len_q   <= rd_len_d;
      cnt_q      <= cnt_d;
      tx_en_q    <= tx_en_d;
      rx_en_q    <= rx_en_d;
      eng_data_q <= eng_data_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign O_eng_tx_en = tx_en_q;
  assign O_eng_rx_en = rx_en_q;
  assign O_eng_data  = eng_data_q;
  assign O_rd_data   = rd_data_q;
  assign O_rd_valid  = rd_valid_q;
  assign O_busy      = busy_q;
  assign O_done      = done_q;
  assign O_err       = err_q;

endmodule

// File: tb/tb_spi_flash_seq.sv
// Bench for spi_flash_seq: 16-clock byte-engine model, show-ahead write FIFO and
// expected-byte queues derived from the transaction request.
module tb_spi_flash_seq;

  logic        I_clk = 1'b0;
  logic        I_rst_n = 1'b0;
  logic        I_start = 1'b0;
  logic [7:0]  I_cmd = 8'h00;
  logic [23:0] I_addr = 24'h0;
  logic        I_addr_en = 1'b0;
  logic [7:0]  I_wr_len = 8'h00;
  logic [7:0]  I_rd_len = 8'h00;
  logic [7:0]  I_wr_data = 8'h00;
  logic        I_eng_tx_done = 1'b0;
  logic        I_eng_rx_done = 1'b0;
  logic [7:0]  I_eng_data = 8'h00;
  logic        O_wr_req, O_rd_valid, O_busy, O_done, O_err, O_eng_tx_en, O_eng_rx_en;
  logic [7:0]  O_rd_data, O_eng_data;

  spi_flash_seq dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_start(I_start), .I_cmd(I_cmd), .I_addr(I_addr),
    .I_addr_en(I_addr_en), .I_wr_len(I_wr_len), .I_rd_len(I_rd_len), .I_wr_data(I_wr_data),
    .O_wr_req(O_wr_req), .O_rd_data(O_rd_data), .O_rd_valid(O_rd_valid), .O_busy(O_busy),
    .O_done(O_done), .O_err(O_err), .O_eng_tx_en(O_eng_tx_en), .O_eng_rx_en(O_eng_rx_en),
    .O_eng_data(O_eng_data), .I_eng_tx_done(I_eng_tx_done), .I_eng_rx_done(I_eng_rx_done),
    .I_eng_data(I_eng_data)
  );

  always #10 I_clk = ~I_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int txn_d0 = 0;
  int n_wr_req = 0;
  int n_rd = 0;
  int hdr_left = 0;
  int pay_left = 0;
  int eng_cnt = 0;
  bit stall = 1'b0;
  bit pop_pending = 1'b0;

  logic [7:0] exp_tx[$], exp_rd[$], slave[$], fifo[$], tx_log[$], rd_log[$], pay_q[$], sl_q[$];

  always @(posedge I_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Engine model, FIFO head and per-cycle comparison against the expected queues.
  always @(negedge I_clk) begin
    logic [7:0] eb;
    if (pop_pending) begin
      if (fifo.size() > 0) void'(fifo.pop_front());
      pop_pending = 1'b0;
    end
    I_eng_tx_done = 1'b0;
    I_eng_rx_done = 1'b0;
    if (!I_rst_n || stall || !(O_eng_tx_en || O_eng_rx_en)) begin
      eng_cnt = 0;
    end else begin
      eng_cnt++;
      if (eng_cnt == 16) begin
        eng_cnt = 0;
        if (O_eng_tx_en) begin
          I_eng_tx_done = 1'b1;
        end else begin
          I_eng_rx_done = 1'b1;
          I_eng_data = (slave.size() > 0) ? slave.pop_front() : 8'h00;
        end
      end
    end
    I_wr_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
    #1;
    if (I_rst_n) begin
      check("not_both_en", 32'(O_eng_tx_en & O_eng_rx_en), 0);
      if (O_busy) check("one_en_busy", 32'(O_eng_tx_en ^ O_eng_rx_en), 1);
      if (I_eng_tx_done) begin
        tx_log.push_back(O_eng_data);
        if (exp_tx.size() == 0) begin
          check("tx_extra_byte", 32'(O_eng_data), 32'h100);
        end else begin
          eb = exp_tx.pop_front();
          check("tx_byte", 32'(O_eng_data), 32'(eb));
        end
        if (hdr_left > 0) hdr_left--;
        else if (pay_left > 0) pay_left--;
        check("wr_req", 32'(O_wr_req), 32'((hdr_left == 0) && (pay_left > 0)));
        if (O_wr_req) begin
          pop_pending = 1'b1;
          n_wr_req++;
        end
      end else begin
        check("wr_req_quiet", 32'(O_wr_req), 0);
      end
      if (O_rd_valid) begin
        n_rd++;
        rd_log.push_back(O_rd_data);
        if (exp_rd.size() == 0) begin
          check("rd_extra_byte", 32'(O_rd_data), 32'h100);
        end else begin
          eb = exp_rd.pop_front();
          check("rd_byte", 32'(O_rd_data), 32'(eb));
        end
      end
      if (O_done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_busy", 32'(O_busy), 0);
        check("done_en", 32'({O_eng_tx_en, O_eng_rx_en}), 0);
        if (O_err) begin
          err_cnt++;
          exp_tx.delete(); exp_rd.delete(); slave.delete(); fifo.delete();
          hdr_left = 0; pay_left = 0;
        end else begin
          check("done_tx_left", exp_tx.size(), 0);
          check("done_rd_left", exp_rd.size(), 0);
        end
      end
      if (!stall) check("err_zero", 32'(O_err), 0);
      else if (O_err) check("err_with_done", 32'(O_done), 1);
    end
  end

  task automatic start_txn(input logic [7:0] c, input logic [23:0] a, input logic ae,
                           input logic [7:0] wl, input logic [7:0] rl);
    logic [7:0] b;
    @(negedge I_clk); #2;
    exp_tx.delete(); exp_rd.delete(); tx_log.delete(); rd_log.delete();
    n_wr_req = 0; n_rd = 0;
    exp_tx.push_back(c);
    hdr_left = 1;
    if (ae) begin
      exp_tx.push_back(a[23:16]); exp_tx.push_back(a[15:8]); exp_tx.push_back(a[7:0]);
      hdr_left = 4;
    end
    for (int i = 0; i < int'(wl); i++) begin
      b = (pay_q.size() > 0) ? pay_q.pop_front() : 8'($urandom);
      fifo.push_back(b); exp_tx.push_back(b);
    end
    pay_left = int'(wl);
    for (int i = 0; i < int'(rl); i++) begin
      b = (sl_q.size() > 0) ? sl_q.pop_front() : 8'($urandom);
      slave.push_back(b); exp_rd.push_back(b);
    end
    pay_q.delete(); sl_q.delete();
    I_cmd = c; I_addr = a; I_addr_en = ae; I_wr_len = wl; I_rd_len = rl;
    I_start = 1'b1;
    t0 = cyc;
    txn_d0 = done_cnt;
    @(negedge I_clk); #2;
    I_start = 1'b0;
    I_cmd = 8'($urandom); I_addr = 24'($urandom); I_addr_en = 1'($urandom);
    I_wr_len = 8'($urandom); I_rd_len = 8'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done_cnt == txn_d0 && k < budget) begin
      @(negedge I_clk); #2;
      k++;
    end
    check("done_seen", done_cnt - txn_d0, 1);
    @(negedge I_clk); #2;
  endtask

  task automatic check_outputs_zero(input string nm);
    check(nm, 32'({O_busy, O_done, O_err, O_eng_tx_en, O_eng_rx_en, O_rd_valid, O_wr_req,
                   O_eng_data, O_rd_data}), 0);
  endtask

  initial begin
    logic [7:0] lit02[6];
    int k, lat;
    lit02 = '{8'h02, 8'h12, 8'h34, 8'h56, 8'hAA, 8'h55};

    repeat (3) @(negedge I_clk);
    #2;
    check_outputs_zero("reset_state");
    I_rst_n = 1'b1;
    @(negedge I_clk); #2;
    check_outputs_zero("idle_after_reset");

    // JEDEC ID read.
    sl_q = '{8'hEF, 8'h40, 8'h18};
    start_txn(8'h9F, 24'h0, 1'b0, 8'd0, 8'd3);
    wait_done(300);
    check("9f_tx_count", tx_log.size(), 1);
    check("9f_tx_byte", 32'(tx_log[0]), 32'h9F);
    check("9f_rd_count", rd_log.size(), 3);
    check("9f_rd0", 32'(rd_log[0]), 32'hEF);
    check("9f_rd1", 32'(rd_log[1]), 32'h40);
    check("9f_rd2", 32'(rd_log[2]), 32'h18);
    check("9f_wr_req", n_wr_req, 0);

    // Page program, two payload bytes.
    pay_q = '{8'hAA, 8'h55};
    start_txn(8'h02, 24'h123456, 1'b1, 8'd2, 8'd0);
    wait_done(300);
    check("02_tx_count", tx_log.size(), 6);
    for (int i = 0; i < 6; i++) check("02_tx_seq", 32'(tx_log[i]), 32'(lit02[i]));
    check("02_wr_req_pulses", n_wr_req, 2);
    check("02_rd_valid", n_rd, 0);

    // Write enable, command only.
    start_txn(8'h06, 24'h0, 1'b0, 8'd0, 8'd0);
    wait_done(100);
    lat = done_cyc - t0;
    check("06_tx_count", tx_log.size(), 1);
    check("06_tx_byte", 32'(tx_log[0]), 32'h06);
    check("06_done_latency_ok", 32'((lat >= 16) && (lat <= 18)), 1);

    // Restart attempt in the address phase must be ignored.
    start_txn(8'h03, 24'hABCDEF, 1'b1, 8'd0, 8'd2);
    repeat (25) @(negedge I_clk);
    #2;
    check("busy_in_addr", 32'(O_busy), 1);
    I_cmd = 8'h55; I_addr = 24'h000000; I_addr_en = 1'b0; I_wr_len = 8'd5; I_rd_len = 8'd0;
    I_start = 1'b1;
    @(negedge I_clk); #2;
    I_start = 1'b0;
    wait_done(400);
    check("03_tx_count", tx_log.size(), 4);
    check("03_rd_count", n_rd, 2);

    // Reset in the middle of the read phase.
    sl_q = '{8'hEF, 8'h40, 8'h18};
    start_txn(8'h9F, 24'h0, 1'b0, 8'd0, 8'd3);
    k = 0;
    while (n_rd < 1 && k < 200) begin
      @(negedge I_clk); #2;
      k++;
    end
    check("rd_before_reset", 32'(n_rd >= 1), 1);
    I_rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset_outputs");
    exp_tx.delete(); exp_rd.delete(); slave.delete(); fifo.delete();
    hdr_left = 0; pay_left = 0; pop_pending = 1'b0;
    repeat (2) @(negedge I_clk);
    #2;
    check_outputs_zero("held_reset_outputs");
    I_rst_n = 1'b1;
    sl_q = '{8'hEF, 8'h40, 8'h18};
    start_txn(8'h9F, 24'h0, 1'b0, 8'd0, 8'd3);
    wait_done(300);
    check("9f_after_reset_rd", rd_log.size(), 3);
    check("9f_after_reset_rd2", 32'(rd_log[2]), 32'h18);

    // Randomised transactions.
    for (int n = 0; n < 8; n++) begin
      start_txn(8'($urandom), 24'($urandom), 1'($urandom),
                8'($urandom_range(0, 4)), 8'($urandom_range(0, 4)));
      wait_done(600);
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    stall = 1'b1;
    k = err_cnt;
    start_txn(8'h05, 24'h0, 1'b0, 8'd0, 8'd1);
    wait_done(200);
    lat = done_cyc - t0;
    check("tmo_err_pulse", err_cnt - k, 1);
    check("tmo_latency_ok", 32'((lat >= 64) && (lat <= 66)), 1);
    stall = 1'b0;
    start_txn(8'h06, 24'h0, 1'b0, 8'd0, 8'd0);
    wait_done(100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not complete, checks %0d", checks);
    $fatal(1, "time limit");
  end

endmodule
